// File: rtl/serial_arith_pkg.sv
// Shared types and the per-bit arithmetic step for the serial arithmetic unit.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CARRY   = 2'd1,
    S_NOCARRY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_PASS   = 2'd0,
    OP_NEGATE = 2'd1,
    OP_INC    = 2'd2,
    OP_DEC    = 2'd3
  } op_t;

  // Result bit plus carry (or borrow for DEC) handed to the next bit.
  typedef struct packed {
    logic r;
    logic c;
  } bit_res_t;

  // NEGATE/INC/DEC all start a word with carry-in 1; PASS has no carry.
  function automatic logic init_carry(op_t op);
    return (op != OP_PASS);
  endfunction

  // One LSB-first step: NEGATE is ~x + 1, INC is x + 1, DEC is x - 1 (borrow chain).
  function automatic bit_res_t bit_step(op_t op, logic b, logic c);
    bit_res_t s;
    s.r = b;
    s.c = 1'b0;
    case (op)
      OP_NEGATE: begin s.r = ~b ^ c; s.c = ~b & c; end
      OP_INC:    begin s.r =  b ^ c; s.c =  b & c; end
      OP_DEC:    begin s.r =  b ^ c; s.c = ~b & c; end
      default:   begin s.r =  b;     s.c = 1'b0;   end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/serial_arith_unit_bit_cnt.sv
// Bit position counter. Clear and enable together load 1, so the start-of-word
// bit (position 0) leaves the counter pointing at position 1.
module serial_bit_cnt #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] r_cnt;

  // Counter holds the position of the next non-sof bit of the word.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)               r_cnt <= '0;
    else if (i_clr || i_en)   r_cnt <= (i_clr ? '0 : r_cnt) + CW'(i_en);
  end

  assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_arith_unit.sv
// Bit-serial PASS/NEGATE/INC/DEC unit. LSB-first operand in, LSB-first result
// out one cycle later, with the assembled word and signed overflow on the MSB.
module serial_arith_unit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sof,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic             out_bit,
  output logic             word_done,
  output logic [WIDTH-1:0] out_word,
  output logic             overflow,
  output logic             frame_err
);

  state_t             r_state;
  op_t                r_op;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_out_word;
  logic               r_overflow;
  logic               r_out_valid;
  logic               r_out_bit;
  logic               r_word_done;
  logic               r_frame_err;

  logic               w_sof;
  logic               w_busy;
  logic               w_take;
  op_t                w_op;
  logic               w_cin;
  bit_res_t           w_step;
  logic               w_cnt_last;
  logic               w_last;
  logic               w_ferr;
  logic               w_cnt_clr;
  logic               w_cnt_en;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_word;
  state_t             w_next_state;

  // A bit is consumed if it starts a word or continues one; a sof always
  // (re)starts, so mode and initial carry come straight from the inputs then.
  assign w_sof   = in_valid & in_sof;
  assign w_busy  = (r_state != S_IDLE);
  assign w_take  = in_valid & (in_sof | w_busy);
  assign w_op    = w_sof ? op_t'(mode) : r_op;
  assign w_cin   = w_sof ? init_carry(op_t'(mode)) : (r_state == S_CARRY);
  assign w_step  = bit_step(w_op, in_bit, w_cin);

  // WIDTH >= 2, so a sof bit is never the MSB.
  assign w_last    = w_take & ~w_sof & w_cnt_last;
  assign w_cnt_clr = w_sof | w_last;
  assign w_cnt_en  = w_take & ~w_last;

  // Framing error: sof inside a word (restart) or a stray bit with no word open.
  assign w_ferr = in_valid & (in_sof ? w_busy : ~w_busy);

  // Signed overflow is carry into the MSB differing from carry out of it.
  assign w_ovf  = (w_op != OP_PASS) & (w_cin ^ w_step.c);
  assign w_word = {w_step.r, r_shift[WIDTH-1:1]};

  serial_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk    (clk),
    .rst_b  (rst_b),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_last (w_cnt_last)
  );

  // Next state: carry state follows the outgoing carry, MSB returns to idle.
  always_comb begin
    w_next_state = r_state;
    if (w_take) begin
      if (w_last)        w_next_state = S_IDLE;
      else if (w_step.c) w_next_state = S_CARRY;
      else               w_next_state = S_NOCARRY;
    end
  end

  // Control state: stalls (in_valid=0) leave state and latched op untouched.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_op    <= OP_PASS;
    end else begin
      r_state <= w_next_state;
      if (w_sof) r_op <= op_t'(mode);
    end
  end

  // Result assembly: shift in each result bit, publish word/overflow on the MSB.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_shift    <= '0;
      r_out_word <= '0;
      r_overflow <= 1'b0;
    end else if (w_take) begin
      r_shift <= w_word;
      if (w_last) begin
        r_out_word <= w_word;
        r_overflow <= w_ovf;
      end
    end
  end

  // Serial output and strobes, one cycle behind the input bit.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_word_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_out_valid <= w_take;
      if (w_take) r_out_bit <= w_step.r;
      r_word_done <= w_last;
      r_frame_err <= w_ferr;
    end
  end

  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign word_done = r_word_done;
  assign out_word  = r_out_word;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed plus randomized bench for serial_arith_unit (WIDTH=8), checked
// against an arithmetic reference model of the four operations.
module tb_serial_arith_unit;

  localparam int W = 8;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));
  localparam logic [1:0] PASS = 2'd0, NEG = 2'd1, INC = 2'd2, DEC = 2'd3;

  logic         clk;
  logic         rst_b;
  logic         in_valid;
  logic         in_bit;
  logic         in_sof;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_bit;
  logic         word_done;
  logic [W-1:0] out_word;
  logic         overflow;
  logic         frame_err;

  int checks = 0;
  int errors = 0;
  int t      = 0;
  int done_t = 0;
  logic [W-1:0] prev_word = '0;
  logic         prev_ovf  = 1'b0;

  serial_arith_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_sof    (in_sof),
    .mode      (mode),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .word_done (word_done),
    .out_word  (out_word),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the word result is plain modular arithmetic on the operand.
  function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] x);
    longint v;
    longint ux = longint'(x);
    case (op)
      NEG:     v = -ux;
      INC:     v = ux + 1;
      DEC:     v = ux - 1;
      default: v = ux;
    endcase
    return W'(v);
  endfunction

  // Reference: overflow when the signed mathematical result leaves the W-bit range.
  function automatic logic ref_ovf(input logic [1:0] op, input logic [W-1:0] x);
    longint s = longint'($signed(x));
    longint r;
    case (op)
      NEG:     r = -s;
      INC:     r = s + 1;
      DEC:     r = s - 1;
      default: r = s;
    endcase
    return (op != PASS) && ((r > MAXS) || (r < MINS));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one input cycle; outputs are observed 1ns after the capturing edge.
  task automatic cyc(input logic v, input logic b, input logic s, input logic [1:0] m);
    in_valid = v;
    in_bit   = b;
    in_sof   = s;
    mode     = m;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
    chk("idle_out_valid", 64'(out_valid), 64'(0));
    chk("idle_word_done", 64'(word_done), 64'(0));
    chk("idle_frame_err", 64'(frame_err), 64'(0));
    chk("idle_word_hold", 64'(out_word), 64'(prev_word));
    chk("idle_ovf_hold",  64'(overflow), 64'(prev_ovf));
  endtask

  // Drive the first n bits of a word (no MSB), checking the serial result.
  task automatic part_word(input logic [1:0] op, input logic [W-1:0] x, input int n);
    logic [W-1:0] res;
    res = ref_res(op, x);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, x[i], i == 0, (i == 0) ? op : 2'($urandom));
      chk("part_out_valid", 64'(out_valid), 64'(1));
      chk("part_out_bit",   64'(out_bit),   64'(res[i]));
      chk("part_word_done", 64'(word_done), 64'(0));
    end
  endtask

  // Full word, optionally stalling stall_len cycles after bit stall_at.
  task automatic run_word(input logic [1:0] op, input logic [W-1:0] x,
                          input int stall_at, input int stall_len, input logic ferr0);
    logic [W-1:0] res;
    int t0;
    res = ref_res(op, x);
    t0  = 0;
    for (int i = 0; i < W; i++) begin
      cyc(1'b1, x[i], i == 0, (i == 0) ? op : 2'($urandom));
      if (i == 0) t0 = t;
      chk("out_valid", 64'(out_valid), 64'(1));
      chk("out_bit",   64'(out_bit),   64'(res[i]));
      chk("word_done", 64'(word_done), 64'(i == W - 1));
      chk("frame_err", 64'(frame_err), 64'((i == 0) && ferr0));
      if (i == W - 1) begin
        chk("out_word",  64'(out_word), 64'(res));
        chk("overflow",  64'(overflow), 64'(ref_ovf(op, x)));
        chk("done_latency", 64'(t - t0), 64'(W - 1 + ((stall_at >= 0) ? stall_len : 0)));
        prev_word = res;
        prev_ovf  = ref_ovf(op, x);
        done_t    = t;
      end else begin
        chk("ovf_hold", 64'(overflow), 64'(prev_ovf));
      end
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          cyc(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
          chk("stall_out_valid", 64'(out_valid), 64'(0));
          chk("stall_word_done", 64'(word_done), 64'(0));
          chk("stall_frame_err", 64'(frame_err), 64'(0));
        end
      end
    end
  endtask

  initial begin
    int d1;
    rst_b    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_sof   = 1'b0;
    mode     = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_bit",   64'(out_bit),   64'(0));
    chk("rst_word_done", 64'(word_done), 64'(0));
    chk("rst_out_word",  64'(out_word),  64'(0));
    chk("rst_overflow",  64'(overflow),  64'(0));
    chk("rst_frame_err", 64'(frame_err), 64'(0));
    rst_b = 1'b1;
    idle_cyc();

    // Directed operations, including the signed-overflow corners.
    run_word(NEG,  8'h05, -1, 0, 1'b0);
    chk("neg05_word", 64'(out_word), 64'(8'hFB));
    run_word(NEG,  8'h80, -1, 0, 1'b0);
    chk("neg80_ovf", 64'(overflow), 64'(1));
    run_word(INC,  8'h7F, -1, 0, 1'b0);
    chk("inc7f_ovf", 64'(overflow), 64'(1));
    run_word(DEC,  8'h00, -1, 0, 1'b0);
    chk("dec00_word", 64'(out_word), 64'(8'hFF));
    run_word(PASS, 8'hA5, -1, 0, 1'b0);
    idle_cyc();

    // Three-cycle stall after bit 2.
    run_word(NEG, 8'h01, 2, 3, 1'b0);
    idle_cyc();

    // Restart: sof on bit 4 aborts the word and begins INC 0x10.
    part_word(NEG, 8'h3C, 4);
    run_word(INC, 8'h10, -1, 0, 1'b1);
    chk("restart_word", 64'(out_word), 64'(8'h11));
    idle_cyc();

    // Asynchronous reset while bit 3 is presented.
    part_word(NEG, 8'h55, 3);
    in_valid = 1'b1;
    in_bit   = 1'b0;
    in_sof   = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_word",  64'(out_word),  64'(0));
    chk("arst_overflow",  64'(overflow),  64'(0));
    chk("arst_word_done", 64'(word_done), 64'(0));
    @(posedge clk);
    #1;
    rst_b     = 1'b1;
    prev_word = '0;
    prev_ovf  = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, NEG);
    chk("stray_out_valid", 64'(out_valid), 64'(0));
    chk("stray_frame_err", 64'(frame_err), 64'(1));
    chk("stray_word_done", 64'(word_done), 64'(0));
    for (int i = 0; i < 6; i++) idle_cyc();

    // Back-to-back words, no bubble between MSB and next sof.
    run_word(NEG, 8'h01, -1, 0, 1'b0);
    d1 = done_t;
    run_word(DEC, 8'h01, -1, 0, 1'b0);
    chk("b2b_word", 64'(out_word), 64'(8'h00));
    chk("b2b_gap",  64'(done_t - d1), 64'(W));

    // Randomized words with random gaps and stalls.
    for (int n = 0; n < 40; n++) begin
      int gaps;
      int sat;
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) idle_cyc();
      sat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 2)) : -1;
      run_word(2'($urandom), W'($urandom), sat, int'($urandom_range(1, 3)), 1'b0);
    end
    idle_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_arith_unit.md
SERIAL_ARITH_UNIT -- requirements
Module: serial_arith_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_b  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_bit is valid this cycle.
REQ-005 SHALL have port in_bit  input  1  serial operand bit, LSB first.
REQ-006 SHALL have port in_sof  input  1  marks the LSB of a new word; qualified by in_valid.
REQ-007 SHALL have port mode  input  2  operation (op_t), sampled only with sof: 00 PASS, 01 NEGATE, 10 INC, 11 DEC.
REQ-008 SHALL have port out_valid  output  1  out_bit valid.
REQ-009 SHALL have port out_bit  output  1  serial result bit, LSB first.
REQ-010 SHALL have port word_done  output  1  one-cycle pulse with the MSB result bit.
REQ-011 SHALL have port out_word  output  WIDTH  parallel result of the last completed word.
REQ-012 SHALL have port overflow  output  1  overflow of the last completed word; valid with word_done, held until the next word_done.
REQ-013 SHALL have port frame_err  output  1  one-cycle framing-error pulse.

Function
REQ-014 SHALL implement states S_IDLE, S_CARRY (carry/borrow = 1) and S_NOCARRY (carry/borrow = 0).
REQ-015 SHALL, on a valid sof, latch mode and enter S_CARRY for NEGATE/INC/DEC, or S_NOCARRY for PASS, with bit counter = 0.
REQ-016 SHALL compute per valid bit b with carry c: PASS r=b; NEGATE r=~b^c, c'=~b&c; INC r=b^c, c'=b&c; DEC r=b^c, c'=~b&c.
REQ-017 SHALL register out_bit and out_valid, giving exactly one cycle latency from in_valid/in_bit.
REQ-018 SHALL hold state, carry and counter unchanged on any cycle with in_valid=0 (stall), and drive out_valid=0 in the following cycle.
REQ-019 SHALL assemble result bits into a shift register and, on bit WIDTH-1, update out_word, assert word_done with that bit's out_valid, and return to S_IDLE.
REQ-020 SHALL set overflow = carry-into-MSB XOR carry-out-of-MSB for NEGATE/INC/DEC, and 0 for PASS.
REQ-021 SHALL treat a valid sof while a word is in progress as a restart: abort the word without word_done, pulse frame_err, and begin the new word using that bit.
REQ-022 SHALL, in S_IDLE, ignore a valid bit without sof (out_valid stays 0) and pulse frame_err.
REQ-023 SHALL ignore in_sof and mode when in_valid=0.
REQ-024 SHALL accept back-to-back words: a sof on the cycle after the MSB is processed without a bubble.

Reset
REQ-025 SHALL, on rst_b low, immediately set the state to S_IDLE, the counter, carry and shift register to 0, and out_valid, out_bit, word_done, out_word, overflow and frame_err to 0.
REQ-026 SHALL discard any partial word on reset mid-operation; no word_done follows for that word.

Structure
REQ-027 SHALL take state_t (S_IDLE, S_CARRY, S_NOCARRY) and op_t (OP_PASS, OP_NEGATE, OP_INC, OP_DEC) from shared package serial_arith_pkg.
REQ-028 SHALL implement the bit position counter, width $clog2(WIDTH), as sub-module serial_bit_cnt with clear, enable and last outputs.
REQ-029 SHALL keep the next-state/output logic combinational and all storage in a single clocked process per register group.

Verification (WIDTH=8)
REQ-030 SHALL verify NEGATE 0x05 -> out_word 0xFB, serial bits 1,1,0,1,1,1,1,1, overflow 0, word_done 8 cycles after sof.
REQ-031 SHALL verify NEGATE 0x80 -> 0x80 with overflow 1; INC 0x7F -> 0x80 with overflow 1; DEC 0x00 -> 0xFF with overflow 0; PASS 0xA5 -> 0xA5 with overflow 0.
REQ-032 SHALL verify NEGATE 0x01 with in_valid low for 3 cycles after bit 2 -> 0xFF, word_done delayed exactly 3 cycles, no out_valid during the stall.
REQ-033 SHALL verify a sof at bit 4 of a word -> frame_err pulse, no word_done for the aborted word, and the new word (INC 0x10 -> 0x11) completing correctly.
REQ-034 SHALL verify rst_b low at bit 3 -> all outputs 0 immediately; a following valid bit without sof -> frame_err, out_valid 0.
REQ-035 SHALL verify back-to-back NEGATE 0x01 and DEC 0x01 -> 0xFF then 0x00, two word_done pulses 8 cycles apart.
